// File: rtl/mem_fill_arbiter.sv
// ============================================================================
// mem_fill_arbiter
// Arbitrates I-cache fills, D-cache fills and D-cache write-through requests
// onto a single pipelined multicycle memory port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_fill_arbiter #(
   parameter int BLOCK_WORDS = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_miss,
   input  logic [15:0]                    i_miss_addr,
   input  logic                           d_miss,
   input  logic [15:0]                    d_miss_addr,
   input  logic                           d_wr,
   input  logic [15:0]                    d_wr_addr,
   input  logic [15:0]                    d_wr_data,
   output logic                           mem_enable,
   output logic                           mem_wr,
   output logic [15:0]                    mem_addr,
   output logic [15:0]                    mem_data_in,
   input  logic [15:0]                    mem_data_out,
   input  logic                           mem_data_valid,
   output logic [15:0]                    fill_data,
   output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
   output logic                           i_fill_we,
   output logic                           d_fill_we,
   output logic                           i_done,
   output logic                           d_done,
   output logic                           wr_done
);

   localparam int                WORD_W     = $clog2(BLOCK_WORDS);
   localparam int                CNT_W      = WORD_W + 1;
   localparam logic [15:0]       ALIGN_MASK = 16'(~((32'd1 << (WORD_W + 1)) - 32'd1));
   localparam logic [CNT_W-1:0]  ISSUE_END  = CNT_W'(BLOCK_WORDS);
   localparam logic [WORD_W-1:0] LAST_WORD  = WORD_W'(BLOCK_WORDS - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FILL  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]        state;
   logic              owner_d;   // 0: I-cache fill, 1: D-cache fill
   logic              op_wr;     // current operation is a write-through
   logic [15:0]       base;
   logic [15:0]       wr_data;
   logic [CNT_W-1:0]  issue_cnt;
   logic [WORD_W-1:0] recv_cnt;

   logic issuing;
   logic receiving;

   assign issuing   = (state == S_FILL) && (issue_cnt < ISSUE_END);
   assign receiving = (state == S_FILL) && mem_data_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         owner_d   <= 1'b0;
         op_wr     <= 1'b0;
         base      <= 16'h0;
         wr_data   <= 16'h0;
         issue_cnt <= '0;
         recv_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_miss) begin
                  owner_d <= 1'b0;
                  op_wr   <= 1'b0;
                  base    <= i_miss_addr & ALIGN_MASK;
                  state   <= S_FILL;
               end else if (d_miss) begin
                  owner_d <= 1'b1;
                  op_wr   <= 1'b0;
                  base    <= d_miss_addr & ALIGN_MASK;
                  state   <= S_FILL;
               end else if (d_wr) begin
                  op_wr   <= 1'b1;
                  base    <= d_wr_addr;
                  wr_data <= d_wr_data;
                  state   <= S_WRITE;
               end
            end
            S_FILL: begin
               if (issuing)
                  issue_cnt <= issue_cnt + 1'b1;
               // Receive side runs independently so any memory latency works.
               if (receiving) begin
                  if (recv_cnt == LAST_WORD) begin
                     state     <= S_DONE;
                     issue_cnt <= '0;
                     recv_cnt  <= '0;
                  end else begin
                     recv_cnt <= recv_cnt + 1'b1;
                  end
               end
            end
            S_WRITE: state <= S_DONE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Outputs are decoded from state and forced low while reset is held.
   always_comb begin
      mem_enable  = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = 16'h0;
      mem_data_in = 16'h0;
      fill_data   = 16'h0;
      fill_word   = '0;
      i_fill_we   = 1'b0;
      d_fill_we   = 1'b0;
      i_done      = 1'b0;
      d_done      = 1'b0;
      wr_done     = 1'b0;
      if (!rst) begin
         case (state)
            S_FILL: begin
               if (issuing) begin
                  mem_enable = 1'b1;
                  mem_addr   = base | 16'({issue_cnt, 1'b0});
               end
               if (receiving) begin
                  fill_data = mem_data_out;
                  fill_word = recv_cnt;
                  i_fill_we = ~owner_d;
                  d_fill_we = owner_d;
               end
            end
            S_WRITE: begin
               mem_enable  = 1'b1;
               mem_wr      = 1'b1;
               mem_addr    = base;
               mem_data_in = wr_data;
            end
            S_DONE: begin
               wr_done = op_wr;
               i_done  = ~op_wr & ~owner_d;
               d_done  = ~op_wr & owner_d;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_fill_arbiter.sv
// ============================================================================
// tb_mem_fill_arbiter
// Directed self-checking bench with a latency / scheduled-valid memory stub.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_fill_arbiter;

   localparam int BW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_miss, d_miss, d_wr;
   logic [15:0]   i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
   logic          mem_enable, mem_wr;
   logic [15:0]   mem_addr, mem_data_in, mem_data_out;
   logic          mem_data_valid;
   logic [15:0]   fill_data;
   logic [2:0]    fill_word;
   logic          i_fill_we, d_fill_we, i_done, d_done, wr_done;
   logic [57:0]   outs;

   int            n_cmp = 0;
   int            n_err = 0;
   int            cyc = 0;
   int            lat = 4;
   bit            mem_auto = 1'b1;
   bit            use_sched = 1'b0;
   int            sched[$];
   logic [15:0]   q_addr[$];
   int            q_due[$];
   int            nf;

   mem_fill_arbiter #(.BLOCK_WORDS(BW)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_miss         (i_miss),
      .i_miss_addr    (i_miss_addr),
      .d_miss         (d_miss),
      .d_miss_addr    (d_miss_addr),
      .d_wr           (d_wr),
      .d_wr_addr      (d_wr_addr),
      .d_wr_data      (d_wr_data),
      .mem_enable     (mem_enable),
      .mem_wr         (mem_wr),
      .mem_addr       (mem_addr),
      .mem_data_in    (mem_data_in),
      .mem_data_out   (mem_data_out),
      .mem_data_valid (mem_data_valid),
      .fill_data      (fill_data),
      .fill_word      (fill_word),
      .i_fill_we      (i_fill_we),
      .d_fill_we      (d_fill_we),
      .i_done         (i_done),
      .d_done         (d_done),
      .wr_done        (wr_done)
   );

   assign outs = {mem_enable, mem_wr, mem_addr, mem_data_in, fill_data, fill_word,
                  i_fill_we, d_fill_we, i_done, d_done, wr_done};

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_fn(input logic [15:0] a);
      return a ^ 16'h5A5A;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; the memory stub records issues and returns data.
   task automatic next_cycle();
      logic v;
      v = 1'b0;
      if (mem_enable && !mem_wr) begin
         q_addr.push_back(mem_addr);
         q_due.push_back(cyc + lat);
      end
      if (mem_auto && mem_data_valid && q_addr.size() > 0) begin
         void'(q_addr.pop_front());
         void'(q_due.pop_front());
      end
      @(posedge clk);
      #1;
      cyc++;
      if (mem_auto) begin
         if (q_addr.size() > 0) begin
            if (use_sched) begin
               foreach (sched[i]) if (sched[i] == cyc) v = 1'b1;
            end else begin
               v = (q_due[0] <= cyc);
            end
         end
         mem_data_valid = v;
         mem_data_out   = v ? mem_fn(q_addr[0]) : 16'h0;
      end
      #1;
   endtask

   // Follow one fill from its sample cycle (cycle 0) to its done pulse.
   task automatic watch(input string tag, input bit is_d, input logic [15:0] base,
                        input int exp_done);
      int nissue, nfill, done_at;
      nissue  = 0;
      nfill   = 0;
      done_at = -1;
      for (int k = 1; k <= 40 && done_at < 0; k++) begin
         next_cycle();
         if (mem_enable) begin
            check({tag, " mem_wr"}, mem_wr, 0);
            check({tag, " issue cyc"}, k, nissue + 1);
            check({tag, " addr"}, mem_addr, base + 16'(2 * nissue));
            nissue++;
         end
         if (i_fill_we || d_fill_we) begin
            check({tag, " owner"}, {i_fill_we, d_fill_we}, is_d ? 2'b01 : 2'b10);
            check({tag, " fill_word"}, fill_word, nfill);
            check({tag, " fill_data"}, fill_data, mem_fn(base + 16'(2 * nfill)));
            nfill++;
         end
         if (i_done || d_done || wr_done) begin
            done_at = k;
            check({tag, " done kind"}, {i_done, d_done, wr_done}, is_d ? 3'b010 : 3'b100);
         end
      end
      check({tag, " done cycle"}, done_at, exp_done);
      check({tag, " issues"}, nissue, BW);
      check({tag, " fills"}, nfill, BW);
   endtask

   initial begin
      rst = 1'b1;
      i_miss = 1'b0; d_miss = 1'b0; d_wr = 1'b0;
      i_miss_addr = 16'h0; d_miss_addr = 16'h0; d_wr_addr = 16'h0; d_wr_data = 16'h0;
      mem_data_valid = 1'b0; mem_data_out = 16'h0;
      repeat (2) @(posedge clk);
      #2;
      check("reset outs", outs, 0);

      // Single I fill, latency 4
      rst = 1'b0; cyc = 0;
      i_miss = 1'b1; i_miss_addr = 16'h1236;
      watch("s1", 1'b0, 16'h1230, 13);
      i_miss = 1'b0;
      next_cycle();
      check("s1 idle outs", outs, 0);

      // Simultaneous I and D misses: I first, then D
      cyc = 0;
      i_miss = 1'b1; i_miss_addr = 16'h0040;
      d_miss = 1'b1; d_miss_addr = 16'h8008;
      watch("s2i", 1'b0, 16'h0040, 13);
      i_miss = 1'b0;
      next_cycle();
      cyc = 0;
      watch("s2d", 1'b1, 16'h8000, 13);
      d_miss = 1'b0;
      next_cycle();

      // Write-through
      cyc = 0;
      d_wr = 1'b1; d_wr_addr = 16'h2002; d_wr_data = 16'hBEEF;
      next_cycle();
      check("s3 en/wr", {mem_enable, mem_wr}, 2'b11);
      check("s3 addr", mem_addr, 16'h2002);
      check("s3 data", mem_data_in, 16'hBEEF);
      check("s3 no strobe", {i_fill_we, d_fill_we}, 2'b00);
      next_cycle();
      check("s3 done", {i_done, d_done, wr_done}, 3'b001);
      check("s3 done idle port", {mem_enable, mem_wr, mem_addr, mem_data_in}, 0);
      d_wr = 1'b0;
      next_cycle();
      check("s3 after", outs, 0);

      // Irregular valid gaps
      use_sched = 1'b1;
      sched = '{5, 7, 8, 12, 13, 15, 16, 18};
      cyc = 0;
      i_miss = 1'b1; i_miss_addr = 16'h3000;
      watch("s4", 1'b0, 16'h3000, 19);
      i_miss = 1'b0; use_sched = 1'b0;
      next_cycle();

      // Reset mid-fill after 3 words
      cyc = 0; nf = 0;
      i_miss = 1'b1; i_miss_addr = 16'h4000;
      repeat (7) begin
         next_cycle();
         if (i_fill_we) nf++;
      end
      check("s5 pre fills", nf, 3);
      next_cycle();
      rst = 1'b1;
      #1;
      check("s5 rst outs", outs, 0);
      q_addr.delete(); q_due.delete();
      mem_data_valid = 1'b0; mem_data_out = 16'h0;
      next_cycle();
      check("s5 rst outs2", outs, 0);
      rst = 1'b0; cyc = 0;
      i_miss_addr = 16'h5006;
      watch("s5r", 1'b0, 16'h5000, 13);
      i_miss = 1'b0;
      next_cycle();

      // Stray valid while idle
      mem_auto = 1'b0;
      mem_data_valid = 1'b1; mem_data_out = 16'h1111;
      #1;
      check("s6 idle valid", {i_fill_we, d_fill_we, fill_word, fill_data}, 0);
      next_cycle();
      check("s6 idle valid2", {i_fill_we, d_fill_we, fill_word, fill_data}, 0);
      mem_data_valid = 1'b0; mem_data_out = 16'h0;
      mem_auto = 1'b1; cyc = 0;
      i_miss = 1'b1; i_miss_addr = 16'h0100;
      watch("s6", 1'b0, 16'h0100, 13);
      i_miss = 1'b0;
      next_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
